// File: rtl/acc_ctrl.sv
// Accumulator controller: sequences LDA/ADD/SUB/NOT through an external 3-bit
// add/sub unit, updating the accumulator and N/Z/C/V flags.
module acc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [2:0] operand,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  output logic       alu_sub,
  input  logic [2:0] alu_s,
  input  logic       alu_cout,
  output logic [2:0] acc,
  output logic       flag_n,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_v,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_LDA = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_NOT = 2'b11
  } op_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_op;
  logic [2:0] r_opd;
  logic [2:0] r_acc;
  logic       r_n;
  logic       r_z;
  logic       r_c;
  logic       r_v;
  logic [2:0] w_acc_new;
  logic       w_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    busy    = 1'b0;
    done    = 1'b0;
    alu_a   = r_acc;
    alu_b   = '0;
    alu_sub = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = EXEC;
      EXEC: begin
        w_next  = DONE;
        busy    = 1'b1;
        alu_b   = r_opd;
        alu_sub = (r_op == OP_SUB);
      end
      DONE: begin
        w_next = IDLE;
        busy   = 1'b1;
        done   = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_acc_new = alu_s;
    w_ovf     = (alu_a[2] == (alu_b[2] ^ alu_sub)) && (alu_s[2] != alu_a[2]);
    case (op_t'(r_op))
      OP_LDA:  w_acc_new = r_opd;
      OP_NOT:  w_acc_new = ~r_acc;
      default: w_acc_new = alu_s;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= '0;
      r_opd <= '0;
      r_acc <= '0;
      r_n   <= 1'b0;
      r_z   <= 1'b1;
      r_c   <= 1'b0;
      r_v   <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_op  <= op;
        r_opd <= operand;
      end
      if (r_state == EXEC) begin
        r_acc <= w_acc_new;
        r_n   <= w_acc_new[2];
        r_z   <= (w_acc_new == '0);
        // C/V only move on arithmetic ops; LDA and NOT keep them
        if (r_op == OP_ADD || r_op == OP_SUB) begin
          r_c <= alu_cout;
          r_v <= w_ovf;
        end
      end
    end
  end

  assign acc    = r_acc;
  assign flag_n = r_n;
  assign flag_z = r_z;
  assign flag_c = r_c;
  assign flag_v = r_v;

endmodule

// File: tb/tb_acc_ctrl.sv
// Self-checking bench for acc_ctrl: directed scenarios plus randomized ops
// against an arithmetic reference model; the add/sub unit is modelled here.
module tb_acc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [2:0] operand;
  logic [2:0] alu_a, alu_b, alu_s;
  logic       alu_sub, alu_cout;
  logic [2:0] acc;
  logic       flag_n, flag_z, flag_c, flag_v, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  int m_acc;
  int m_n, m_z, m_c, m_v;

  acc_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .operand(operand),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub),
    .alu_s(alu_s), .alu_cout(alu_cout), .acc(acc),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // companion 3-bit add/sub unit
  always_comb begin
    int ia, ib, r;
    ia = int'(alu_a);
    ib = int'(alu_b);
    if (alu_sub) r = ia + (7 - ib) + 1;
    else         r = ia + ib;
    alu_s    = 3'(r % 8);
    alu_cout = (r >= 8);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sgn3(input int v);
    return (v >= 4) ? v - 8 : v;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_n = 0; m_z = 1; m_c = 0; m_v = 0;
  endtask

  task automatic model_apply(input int o, input int d);
    int r, s;
    case (o)
      0: m_acc = d;
      1: begin
        r = m_acc + d;
        s = sgn3(m_acc) + sgn3(d);
        m_c = (r >= 8);
        m_v = (s > 3 || s < -4);
        m_acc = r % 8;
      end
      2: begin
        r = m_acc - d;
        s = sgn3(m_acc) - sgn3(d);
        m_c = (m_acc >= d);
        m_v = (s > 3 || s < -4);
        m_acc = (r + 8) % 8;
      end
      default: m_acc = 7 - m_acc;
    endcase
    m_n = (m_acc >= 4);
    m_z = (m_acc == 0);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".acc"}, int'(acc), m_acc);
    chk({tag, ".nzcv"}, int'({flag_n, flag_z, flag_c, flag_v}),
        m_n * 8 + m_z * 4 + m_c * 2 + m_v);
  endtask

  task automatic do_op(input string tag, input int o, input int d);
    @(negedge clk);
    start = 1'b1; op = 2'(o); operand = 3'(d);
    chk({tag, ".idle_busy"}, int'(busy), 0);
    chk({tag, ".idle_alub"}, int'({alu_b, alu_sub}), 0);
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom_range(3)); operand = 3'($urandom_range(7));
    chk({tag, ".exec_bd"}, int'({busy, done}), 2);
    chk({tag, ".exec_a"}, int'(alu_a), m_acc);
    chk({tag, ".exec_b"}, int'(alu_b), d);
    chk({tag, ".exec_sub"}, int'(alu_sub), (o == 2) ? 1 : 0);
    chk_state({tag, ".exec_hold"});
    model_apply(o, d);
    @(posedge clk); #1;
    chk({tag, ".done_bd"}, int'({busy, done}), 3);
    chk({tag, ".done_sub"}, int'(alu_sub), 0);
    chk_state({tag, ".done"});
    @(posedge clk); #1;
    chk({tag, ".after_bd"}, int'({busy, done}), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".acc"}, int'(acc), 0);
    chk({tag, ".nzcv"}, int'({flag_n, flag_z, flag_c, flag_v}), 4);
    chk({tag, ".bd"}, int'({busy, done}), 0);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; op = '0; operand = '0;
    model_reset();
    #12;
    chk_reset_vals("rst_held");
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_reset_vals("rst_idle");
    end

    do_op("lda011", 0, 3);
    do_op("add010", 1, 2);
    chk("r031_acc", int'(acc), 5);

    do_op("lda101", 0, 5);
    do_op("sub101", 2, 5);
    chk("r032_flags", int'({flag_n, flag_z, flag_c, flag_v}), 6);

    do_op("lda111", 0, 7);
    do_op("add001", 1, 1);
    chk("r033_wrap", int'({acc, flag_c, flag_z, flag_v}), 6);
    do_op("not", 3, 0);
    chk("r033_not", int'({acc, flag_n, flag_c, flag_v}), 62);

    // start held through two full operations
    do_op("lda000", 0, 0);
    @(negedge clk);
    start = 1'b1; op = 2'b01; operand = 3'd1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    @(negedge clk); start = 1'b0;
    model_apply(1, 1); model_apply(1, 1);
    chk("held_dones", dones, 2);
    chk("held_busy", int'(busy), 0);
    chk_state("held");
    chk("held_acc", int'(acc), 2);

    // asynchronous reset mid-EXEC
    @(negedge clk);
    start = 1'b1; op = 2'b01; operand = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_in_exec", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("abort_rst");
    #1 rst = 1'b0;
    model_reset();
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort_nodone", dones, 0);
    chk_reset_vals("abort_after");
    do_op("lda100", 0, 4);
    chk("r035_n", int'({acc, flag_n}), 9);

    // randomized operations with occasional idle gaps
    for (int i = 0; i < 150; i++) begin
      do_op("rnd", int'($urandom_range(3)), int'($urandom_range(7)));
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(3)) @(posedge clk);
        #1;
        chk("rnd_idle_bd", int'({busy, done}), 0);
        chk_state("rnd_idle");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
